// File: rtl/dec_3to8_if.sv
// Select/strobe bus for the registered 3-to-8 decoder.
// `err` exists only when DEC_3TO8_ONEHOT_CHECK_EN is defined.
interface dec_3to8_if;
  logic en;
  logic s0;
  logic s1;
  logic s2;
  logic o0;
  logic o1;
  logic o2;
  logic o3;
  logic o4;
  logic o5;
  logic o6;
  logic o7;
  logic valid;
`ifdef DEC_3TO8_ONEHOT_CHECK_EN
  logic err;
`endif

`ifdef DEC_3TO8_ONEHOT_CHECK_EN
  modport master (
    output en, s0, s1, s2,
    input  o0, o1, o2, o3, o4, o5, o6, o7, valid, err
  );
  modport slave (
    input  en, s0, s1, s2,
    output o0, o1, o2, o3, o4, o5, o6, o7, valid, err
  );
`else
  modport master (
    output en, s0, s1, s2,
    input  o0, o1, o2, o3, o4, o5, o6, o7, valid
  );
  modport slave (
    input  en, s0, s1, s2,
    output o0, o1, o2, o3, o4, o5, o6, o7, valid
  );
`endif
endinterface

// File: rtl/dec_3to8.sv
// Registered 3-to-8 one-hot decoder, one clock of latency, one decode per clock.
// Optional sticky one-hot checker on the registered outputs: DEC_3TO8_ONEHOT_CHECK_EN.
module dec_3to8 (
  input  logic        clk,
  input  logic        rst_n,
  dec_3to8_if.slave   bus
);

  logic [2:0] idx;
  logic [7:0] o_d;
  logic [7:0] o_q;
  logic       valid_d;
  logic       valid_q;

  assign idx = {bus.s2, bus.s1, bus.s0};

  // Disabled cycles clear the outputs rather than holding the last decode.
  always_comb begin
    o_d     = 8'd0;
    valid_d = bus.en;
    if (bus.en) begin
      o_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q     <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      o_q     <= o_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o0    = o_q[0];
  assign bus.o1    = o_q[1];
  assign bus.o2    = o_q[2];
  assign bus.o3    = o_q[3];
  assign bus.o4    = o_q[4];
  assign bus.o5    = o_q[5];
  assign bus.o6    = o_q[6];
  assign bus.o7    = o_q[7];
  assign bus.valid = valid_q;

`ifdef DEC_3TO8_ONEHOT_CHECK_EN
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, v[i]};
    end
    return cnt;
  endfunction

  logic [3:0] pop;
  logic       err_d;
  logic       err_q;

  // More than one bit set is the only illegal state; all-zero is a disabled cycle.
  always_comb begin
    pop   = popcount8(o_q);
    err_d = err_q | (pop > 4'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_dec_3to8.sv
// Directed-vector bench for dec_3to8 with a reference model checked every cycle.
module tb_dec_3to8;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  bit   started;

  dec_3to8_if bus ();

  dec_3to8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] dut_o;
  assign dut_o = {bus.o7, bus.o6, bus.o5, bus.o4, bus.o3, bus.o2, bus.o1, bus.o0};

  // Reference model: the output word is 2**idx when enabled, zero otherwise.
  logic [7:0] exp_o;
  logic       exp_v;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_o <= 8'd0;
      exp_v <= 1'b0;
    end else begin
      exp_o <= bus.en ? 8'(2 ** int'({bus.s2, bus.s1, bus.s0})) : 8'd0;
      exp_v <= bus.en;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_o", dut_o, exp_o);
      chk("model_valid", {7'd0, bus.valid}, {7'd0, exp_v});
`ifdef DEC_3TO8_ONEHOT_CHECK_EN
      chk("err", {7'd0, bus.err}, 8'd0);
`endif
    end
  end

  task automatic drive(input logic en, input logic [2:0] idx);
    bus.en = en;
    {bus.s2, bus.s1, bus.s0} = idx;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    started = 1'b0;
    rst_n   = 1'b0;
    drive(1'b0, 3'd0);

    // Reset held with random inputs and clock running.
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      started = 1'b1;
    end
    chk("reset_o", dut_o, 8'h00);
    chk("reset_valid", {7'd0, bus.valid}, 8'd0);

    drive(1'b0, 3'd0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", dut_o, 8'h00);

    // Sweep 0..7.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i));
      tick();
      chk("sweep_o", dut_o, 8'(1 << i));
      chk("sweep_valid", {7'd0, bus.valid}, 8'd1);
    end
    chk("sweep_last", dut_o, 8'b1000_0000);

    // idx 5 held three cycles, then disabled.
    drive(1'b1, 3'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold5", dut_o, 8'b0010_0000);
    end
    drive(1'b0, 3'd5);
    tick();
    chk("disable_o", dut_o, 8'h00);
    chk("disable_valid", {7'd0, bus.valid}, 8'd0);

    // Alternate 7 and 0.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i % 2 == 0) ? 3'd7 : 3'd0);
      tick();
      chk("alt", dut_o, (i % 2 == 0) ? 8'b1000_0000 : 8'b0000_0001);
    end

    // idx 3 steady with an asynchronous reset pulse mid-cycle.
    drive(1'b1, 3'd3);
    tick();
    chk("steady3", dut_o, 8'b0000_1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear_o", dut_o, 8'h00);
    chk("async_clear_valid", {7'd0, bus.valid}, 8'd0);
    tick();
    chk("reset_held_o", dut_o, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("after_release", dut_o, 8'b0000_1000);
    chk("after_release_valid", {7'd0, bus.valid}, 8'd1);

    // Sweep with en toggling.
    for (int i = 0; i < 16; i++) begin
      drive(1'(i % 2), 3'(i % 8));
      tick();
      chk("toggle", dut_o, (i % 2 == 1) ? 8'(1 << (i % 8)) : 8'h00);
    end

    drive(1'b0, 3'd0);
    tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
